// File: rtl/riscv_axi_lite_master_if.sv
// AXI4-Lite master port bundle for the core's external bus.
interface riscv_axi_lite_master_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/riscv_axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator for core accesses
// outside local memory, with a transaction watchdog.
module riscv_axi_lite_master #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        riscv_cpu_clk,
  input  logic        riscv_cpu_reset,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_wr,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [3:0]  cpu_req_wstrb,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  riscv_axi_lite_master_if.master m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } state_t;

  state_t                state;
  logic [15:0]           wd_cnt;
  logic [16:0]           wd_nxt;
  logic                  wd_fire;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_now;
  logic                  w_now;
  logic                  busy;
  logic                  step;
  logic                  is_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  unused_addr;

  assign req_addr    = {cpu_req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr = ^{cpu_req_addr[31:ADDR_WIDTH],
                         cpu_req_addr[1:0]};
  assign wd_nxt      = {1'b0, wd_cnt} + 17'd1;
  assign wd_fire     = (TIMEOUT_CYCLES != 0) &&
                       (wd_nxt == 17'(TIMEOUT_CYCLES));
  assign aw_now      = aw_done | (m_axi.awvalid & m_axi.awready);
  assign w_now       = w_done  | (m_axi.wvalid  & m_axi.wready);
  assign is_rd       = (state == S_RD_ADDR) || (state == S_RD_DATA);

  // step marks a cycle where the current phase completes
  always_comb begin
    busy = 1'b0;
    step = 1'b0;
    unique case (state)
      S_RD_ADDR: begin busy = 1'b1; step = m_axi.arready; end
      S_RD_DATA: begin busy = 1'b1; step = m_axi.rvalid;  end
      S_WR_REQ:  begin busy = 1'b1; step = aw_now & w_now; end
      S_WR_RESP: begin busy = 1'b1; step = m_axi.bvalid;  end
      default:   begin busy = 1'b0; step = 1'b0;          end
    endcase
  end

  always_ff @(posedge riscv_cpu_clk) begin
    if (riscv_cpu_reset) begin
      state          <= S_IDLE;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      cpu_resp_err   <= 1'b0;
      m_axi.araddr   <= '0;
      m_axi.arvalid  <= 1'b0;
      m_axi.rready   <= 1'b0;
      m_axi.awaddr   <= '0;
      m_axi.awvalid  <= 1'b0;
      m_axi.wdata    <= '0;
      m_axi.wstrb    <= '0;
      m_axi.wvalid   <= 1'b0;
      m_axi.bready   <= 1'b0;
      wd_cnt         <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
    end else begin
      cpu_resp_valid <= 1'b0;
      if (busy) wd_cnt <= wd_nxt[15:0];
      unique case (state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            cpu_req_ready <= 1'b0;
            wd_cnt        <= '0;
            m_axi.araddr  <= req_addr;
            m_axi.awaddr  <= req_addr;
            m_axi.wdata   <= cpu_req_wdata;
            m_axi.wstrb   <= cpu_req_wstrb;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            if (cpu_req_wr) begin
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= S_WR_REQ;
            end else begin
              m_axi.arvalid <= 1'b1;
              state         <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready   <= 1'b0;
            cpu_resp_rdata <= m_axi.rdata;
            cpu_resp_err   <= |m_axi.rresp;
            cpu_resp_valid <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_WR_REQ: begin
          if (m_axi.awvalid & m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (m_axi.wvalid & m_axi.wready) begin
            m_axi.wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_now & w_now) begin
            m_axi.bready <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready   <= 1'b0;
            cpu_resp_rdata <= '0;
            cpu_resp_err   <= |m_axi.bresp;
            cpu_resp_valid <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_req_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A completing handshake on the limit cycle beats the watchdog
      if (busy && !step && wd_fire) begin
        m_axi.arvalid  <= 1'b0;
        m_axi.rready   <= 1'b0;
        m_axi.awvalid  <= 1'b0;
        m_axi.wvalid   <= 1'b0;
        m_axi.bready   <= 1'b0;
        cpu_resp_rdata <= is_rd ? 32'hFFFF_FFFF : 32'h0;
        cpu_resp_err   <= 1'b1;
        cpu_resp_valid <= 1'b1;
        state          <= S_RESP;
      end
    end
  end

endmodule

// File: tb/tb_riscv_axi_lite_master.sv
// Bench for riscv_axi_lite_master: scripted slave memory,
// directed timing scenarios and a random scoreboarded stream.
module tb_riscv_axi_lite_master;
  localparam int AW = 14;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_wr;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [3:0]  cpu_req_wstrb;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;

  riscv_axi_lite_master_if #(.ADDR_WIDTH(AW)) axi ();

  riscv_axi_lite_master #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .riscv_cpu_clk  (clk),
    .riscv_cpu_reset(rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_wr     (cpu_req_wr),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_wstrb  (cpu_req_wstrb),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_err   (cpu_resp_err),
    .m_axi          (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  int errors = 0;
  int checks = 0;

  int       ar_wait = 0, r_wait = 0, aw_wait = 0;
  int       w_wait = 0, b_wait = 0;
  bit       ar_never = 0, b_never = 0;
  logic [1:0] rresp_v = 2'b00, bresp_v = 2'b00;
  logic [31:0] smem [int];
  logic [31:0] mmem [int];

  bit [63:0]   tr_ar, tr_aw, tr_w, tr_r, tr_b;
  logic [AW-1:0] cap_araddr, cap_awaddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, rd_key, wa_key;
    logic [31:0] wd_cap, cur;
    logic [3:0]  ws_cap;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_key = 0; wa_key = 0; wd_cap = 0; ws_cap = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0;
    axi.rresp = 0; axi.awready = 0; axi.wready = 0;
    axi.bvalid = 0; axi.bresp = 0;
    forever begin
      @(negedge clk);
      if (axi.arvalid && !ar_never) begin
        if (ar_cnt == ar_wait) begin
          axi.arready = 1;
          rd_key = int'(axi.araddr[AW-1:2]);
        end else begin
          axi.arready = 0; ar_cnt++;
        end
      end else begin
        axi.arready = 0; ar_cnt = 0;
      end
      if (axi.rready) begin
        if (r_cnt == r_wait) begin
          axi.rvalid = 1;
          axi.rdata = smem.exists(rd_key) ? smem[rd_key] : 32'h0;
          axi.rresp = rresp_v;
        end else begin
          axi.rvalid = 0; r_cnt++;
        end
      end else begin
        axi.rvalid = 0; r_cnt = 0;
      end
      if (axi.awvalid) begin
        if (aw_cnt == aw_wait) begin
          axi.awready = 1;
          wa_key = int'(axi.awaddr[AW-1:2]);
        end else begin
          axi.awready = 0; aw_cnt++;
        end
      end else begin
        axi.awready = 0; aw_cnt = 0;
      end
      if (axi.wvalid) begin
        if (w_cnt == w_wait) begin
          axi.wready = 1;
          wd_cap = axi.wdata; ws_cap = axi.wstrb;
        end else begin
          axi.wready = 0; w_cnt++;
        end
      end else begin
        axi.wready = 0; w_cnt = 0;
      end
      if (axi.bready && !b_never) begin
        if (b_cnt == b_wait) begin
          if (!axi.bvalid) begin
            cur = smem.exists(wa_key) ? smem[wa_key] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (ws_cap[b]) cur[8*b +: 8] = wd_cap[8*b +: 8];
            smem[wa_key] = cur;
          end
          axi.bvalid = 1; axi.bresp = bresp_v;
        end else begin
          axi.bvalid = 0; b_cnt++;
        end
      end else begin
        axi.bvalid = 0; b_cnt = 0;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output logic er,
                       output int lat);
    int n;
    tr_ar = 0; tr_aw = 0; tr_w = 0; tr_r = 0; tr_b = 0;
    rd = 32'h0; er = 1'b0; lat = 0;
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_wr = wr; cpu_req_addr = a;
    cpu_req_wdata = wd; cpu_req_wstrb = ws;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    cpu_req_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        cap_araddr = axi.araddr; cap_awaddr = axi.awaddr;
        cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
      end
      tr_ar[k] = axi.arvalid; tr_aw[k] = axi.awvalid;
      tr_w[k] = axi.wvalid; tr_r[k] = axi.rready;
      tr_b[k] = axi.bready;
      if (cpu_resp_valid) begin
        rd = cpu_resp_rdata; er = cpu_resp_err; lat = k;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL resp_timeout: no cpu_resp_valid within 40 cycles, addr %h", a);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cpu_req_ready);
    end
    checks++;
    if ({cpu_resp_valid, cpu_resp_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp: got %b want 00", {cpu_resp_valid, cpu_resp_err});
    end
    checks++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi_ctl: got %b want 00000",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    checks++;
    if ({axi.araddr, axi.awaddr, axi.wdata, axi.wstrb, cpu_resp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_fields: araddr %h awaddr %h wdata %h wstrb %h rdata %h want all 0",
               axi.araddr, axi.awaddr, axi.wdata, axi.wstrb, cpu_resp_rdata);
    end
  endtask

  task automatic test_zero_wait_read();
    logic [31:0] rd; logic er; int lat;
    smem[12'h48D] = 32'hDEAD_BEEF;
    issue(0, 32'h0000_1234, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL rd0_latency: got %0d want 3", lat);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd0_data: got %h want deadbeef", rd);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL rd0_err: got %b want 0", er);
    end
    checks++;
    if (cap_araddr !== 14'h1234) begin
      errors++; $display("FAIL rd0_araddr: got %h want 1234", cap_araddr);
    end
    checks++;
    if (tr_ar !== 64'h2) begin
      errors++; $display("FAIL rd0_arvalid_trace: got %h want 2", tr_ar);
    end
    checks++;
    if (tr_r !== 64'h4) begin
      errors++; $display("FAIL rd0_rready_trace: got %h want 4", tr_r);
    end
    issue(0, 32'hFFFF_5237, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (cap_araddr !== 14'h1234) begin
      errors++; $display("FAIL rd_addr_mask: got %h want 1234", cap_araddr);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_mask_data: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_write_aw_first();
    logic [31:0] rd; logic er; int lat;
    smem[12'h010] = 32'hAABB_CCDD;
    aw_wait = 0; w_wait = 3; b_wait = 0;
    issue(1, 32'h0000_0040, 32'h1122_3344, 4'b0110, rd, er, lat);
    w_wait = 0;
    checks++;
    if (tr_aw !== 64'h2) begin
      errors++; $display("FAIL awfirst_awvalid: got %h want 2", tr_aw);
    end
    checks++;
    if (tr_w !== 64'h1E) begin
      errors++; $display("FAIL awfirst_wvalid: got %h want 1e", tr_w);
    end
    checks++;
    if (tr_b !== 64'h20) begin
      errors++; $display("FAIL awfirst_bready: got %h want 20", tr_b);
    end
    checks++;
    if (lat != 6) begin
      errors++; $display("FAIL awfirst_latency: got %0d want 6", lat);
    end
    checks++;
    if ({er, rd} !== 33'h0) begin
      errors++; $display("FAIL awfirst_resp: got err %b rdata %h want 0 0", er, rd);
    end
    checks++;
    if ({cap_awaddr, cap_wdata, cap_wstrb} !== {14'h0040, 32'h1122_3344, 4'b0110}) begin
      errors++;
      $display("FAIL awfirst_fields: got %h %h %b want 0040 11223344 0110",
               cap_awaddr, cap_wdata, cap_wstrb);
    end
    checks++;
    if (smem[12'h010] !== 32'hAA22_33DD) begin
      errors++;
      $display("FAIL awfirst_mem: got %h want aa2233dd", smem[12'h010]);
    end
  endtask

  task automatic test_write_w_first();
    logic [31:0] rd; logic er; int lat;
    aw_wait = 2; w_wait = 0; b_wait = 0;
    issue(1, 32'h0000_0040, 32'h1122_3344, 4'b0110, rd, er, lat);
    aw_wait = 0;
    checks++;
    if (tr_w !== 64'h2) begin
      errors++; $display("FAIL wfirst_wvalid: got %h want 2", tr_w);
    end
    checks++;
    if (tr_aw !== 64'hE) begin
      errors++; $display("FAIL wfirst_awvalid: got %h want e", tr_aw);
    end
    checks++;
    if (tr_b !== 64'h10) begin
      errors++; $display("FAIL wfirst_bready: got %h want 10", tr_b);
    end
    checks++;
    if (lat != 5 || er !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_resp: got lat %0d err %b want 5 0", lat, er);
    end
  endtask

  task automatic test_slave_error();
    logic [31:0] rd; logic er; int lat;
    smem[12'h080] = 32'h0BAD_F00D;
    rresp_v = 2'b10;
    issue(0, 32'h0000_0200, 32'h0, 4'h0, rd, er, lat);
    rresp_v = 2'b00;
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL rd_slverr_err: got %b want 1", er);
    end
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rd_slverr_data: got %h want 0badf00d", rd);
    end
    bresp_v = 2'b11;
    issue(1, 32'h0000_0204, 32'h5555_AAAA, 4'hF, rd, er, lat);
    bresp_v = 2'b00;
    checks++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wr_decerr: got err %b rdata %h want 1 0", er, rd);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd; logic er; int lat;
    ar_never = 1;
    issue(0, 32'h0000_0300, 32'h0, 4'h0, rd, er, lat);
    ar_never = 0;
    checks++;
    if (tr_ar !== 64'h1FE) begin
      errors++; $display("FAIL wdog_arvalid: got %h want 1fe", tr_ar);
    end
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL wdog_latency: got %0d want 9", lat);
    end
    checks++;
    if ({er, rd} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wdog_rd_resp: got err %b rdata %h want 1 ffffffff", er, rd);
    end
    smem[12'h0C0] = 32'h1234_5678;
    issue(0, 32'h0000_0300, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if ({er, rd, lat} !== {1'b0, 32'h1234_5678, 32'd3}) begin
      errors++;
      $display("FAIL wdog_recover: got err %b rdata %h lat %0d want 0 12345678 3", er, rd, lat);
    end
    b_never = 1;
    issue(1, 32'h0000_0308, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    b_never = 0;
    checks++;
    if ({er, rd, lat} !== {1'b1, 32'h0, 32'd9}) begin
      errors++;
      $display("FAIL wdog_wr_resp: got err %b rdata %h lat %0d want 1 0 9", er, rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int n; int pulses;
    b_wait = 6;
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_wr = 1; cpu_req_addr = 32'h0000_0500;
    cpu_req_wdata = 32'h7777_7777; cpu_req_wstrb = 4'hF;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    cpu_req_valid = 0;
    n = 0;
    while (!axi.bready && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (axi.bready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach_wr_resp: got bready %b want 1", axi.bready);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_axi_ctl: got %b want 00000",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    checks++;
    if ({cpu_req_ready, cpu_resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_cpu: got ready/resp %b want 10", {cpu_req_ready, cpu_resp_valid});
    end
    rst = 0;
    b_wait = 0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_resp_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", pulses);
    end
    issue(0, 32'h0000_1234, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if ({er, rd, lat} !== {1'b0, 32'hDEAD_BEEF, 32'd3}) begin
      errors++;
      $display("FAIL rstmid_after_read: got err %b rdata %h lat %0d want 0 deadbeef 3",
               er, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int n_acc = 0;
    int n_resp = 0;
    bit prev = 0;
    int idx;
    bit w, er;
    logic [31:0] d, cur;
    logic [3:0] s;
    cpu_req_valid = 0;
    for (int cyc = 0; cyc < 3000 && n_resp < 100; cyc++) begin
      @(negedge clk);
      if (prev) begin
        checks++;
        if (cpu_req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_after_resp: got %b want 1 (resp %0d)", cpu_req_ready, n_resp);
        end
      end
      prev = cpu_resp_valid;
      if (cpu_resp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_resp: got response %0d with none outstanding", n_resp);
        end else begin
          e = q.pop_front();
          if ({cpu_resp_err, cpu_resp_rdata} !== {e.er, e.rd}) begin
            errors++;
            $display("FAIL b2b_resp_%0d: got err %b rdata %h want err %b rdata %h",
                     n_resp, cpu_resp_err, cpu_resp_rdata, e.er, e.rd);
          end
        end
        n_resp++;
      end
      if (cpu_req_ready && n_acc < 100) begin
        w = 1'($urandom_range(0, 1));
        idx = 'h100 + int'($urandom_range(0, 15));
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        er = ($urandom_range(0, 7) == 0);
        cpu_req_valid = 1;
        cpu_req_wr = w;
        cpu_req_addr = ($urandom & 32'hFFFF_C000) | (idx << 2) | $urandom_range(0, 3);
        cpu_req_wdata = d;
        cpu_req_wstrb = s;
        ar_wait = $urandom_range(0, 2); r_wait = $urandom_range(0, 2);
        aw_wait = $urandom_range(0, 2); w_wait = $urandom_range(0, 2);
        b_wait = $urandom_range(0, 2);
        rresp_v = er ? 2'b10 : 2'b00;
        bresp_v = er ? 2'b11 : 2'b00;
        if (w) begin
          cur = mmem.exists(idx) ? mmem[idx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
          mmem[idx] = cur;
          e.rd = 32'h0;
        end else begin
          e.rd = mmem.exists(idx) ? mmem[idx] : 32'h0;
        end
        e.er = er;
        q.push_back(e);
        n_acc++;
      end else if (cpu_req_ready) begin
        cpu_req_valid = 0;
      end
    end
    cpu_req_valid = 0;
    checks++;
    if (n_resp != 100 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses, %0d outstanding, want 100 and 0",
               n_resp, q.size());
    end
  endtask

  initial begin
    rst = 1; cpu_req_valid = 0; cpu_req_wr = 0;
    cpu_req_addr = 0; cpu_req_wdata = 0; cpu_req_wstrb = 0;
    test_reset();
    test_zero_wait_read();
    test_write_aw_first();
    test_write_w_first();
    test_slave_error();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/riscv_axi_lite_master.md
# riscv_axi_lite_master

AXI4-Lite initiator that lets the RISC-V core reach memory-mapped space outside the local ideal memory. It takes single-beat word requests from the core, drives AR/R or AW/W/B on an AXI4-Lite master port, and returns read data and status to the core. At most one transaction is in flight. A watchdog turns an unanswered transaction into an error response.

## Interface
- ADDR_WIDTH, 14: AXI address width; request address bits [ADDR_WIDTH-1:0] are used.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles, range 0..65535; 0 disables the watchdog.
- riscv_cpu_clk  in  1  sole clock; all logic samples on its rising edge
- riscv_cpu_reset  in  1  reset: one clock, synchronous, active-high
- cpu_req_valid  in  1  core request present
- cpu_req_ready  out  1  block accepts a request this cycle
- cpu_req_wr  in  1  1 = write, 0 = read
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  32  write data
- cpu_req_wstrb  in  4  byte enables for writes
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_rdata  out  32  read data; 0 for writes
- cpu_resp_err  out  1  SLVERR/DECERR received, or watchdog fired
- m_axi_araddr/arvalid/arready: out ADDR_WIDTH / out 1 / in 1
- m_axi_rdata/rresp/rvalid/rready: in 32 / in 2 / in 1 / out 1
- m_axi_awaddr/awvalid/awready: out ADDR_WIDTH / out 1 / in 1
- m_axi_wdata/wstrb/wvalid/wready: out 32 / out 4 / out 1 / in 1
- m_axi_bresp/bvalid/bready: in 2 / in 1 / out 1

## Operation
States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.

- **IDLE.** cpu_req_ready=1 and all AXI valids/readies are 0.
- **Request accept.** A request is accepted when cpu_req_valid & cpu_req_ready.
  - Registered: address as {addr[ADDR_WIDTH-1:2],2'b00}, wdata, and wstrb.
  - Next state: RD_ADDR for a read, WR_REQ for a write.
- **RD_ADDR.** arvalid=1. On arvalid&arready, go to RD_DATA.
- **RD_DATA.** rready=1. On rvalid:
  - capture rdata;
  - err = (rresp != 2'b00);
  - go to RESP.
- **WR_REQ.** awvalid and wvalid are both raised on entry.
  - Each drops independently after its own handshake; aw_done and w_done flags track this.
  - When both are done (same-cycle completion allowed), go to WR_RESP.
- **WR_RESP.** bready=1. On bvalid: err = (bresp != 0), go to RESP.
- **RESP.** cpu_resp_valid=1 for exactly one cycle, then go to IDLE. cpu_req_ready=0.
- **Watchdog.** A 16-bit counter clears on request accept and increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES, all valids/readies drop the next cycle and the FSM goes to RESP.
  - The response is err=1 with rdata=32'hFFFF_FFFF for reads, matching the memory-contention convention, and 0 for writes.
  - A handshake in the same cycle as the limit wins over the timeout.
- **Stability.** While valid is asserted, AXI address, data and strobe stay stable. They change only on accept.
- **Reset.** riscv_cpu_reset high on any edge forces IDLE and clears all outputs, regardless of any pending handshake. Abandoning a transaction is acceptable because the slave side is reset by the same signal.

## Timing
Reset values:
- cpu_req_ready=1; all other outputs 0.
- The address, data and resp fields are 0.

Latency, with the request accepted at edge T:
- Read with zero-wait slave: arvalid at T+1, AR handshake at T+1, rready at T+2, R handshake at T+2, cpu_resp_valid at T+3, next accept possible at T+4.
- Write with zero-wait slave: AW and W handshakes at T+1, B at T+2, resp at T+3.

Further rules:
- Each slave wait cycle adds one cycle.
- Slave readiness never reaches the core-side outputs combinationally.
- Early bvalid or rvalid (before the FSM is in RD_DATA or WR_RESP) is ignored; the slave must hold it.

## Test plan
- **Zero-wait read.** Read addr 0x0000_1234, slave returns rdata 0xDEADBEEF, rresp 0 -> araddr=0x1234, resp_valid at T+3, rdata=0xDEADBEEF, err=0.
- **Write, AW before W.** Write addr 0x40, wdata 0x1122_3344, wstrb 4'b0110; slave asserts awready at T+1 and wready at T+4 -> awvalid drops after T+1, wvalid held until T+4, bready from T+5, resp err=0.
- **Write, W before AW.** Same transfer with wready at T+1 and awready at T+3 -> wvalid held through T+1, awvalid held through T+3, bready from T+4.
- **Slave error.** Read with rresp=2'b10 -> err=1, rdata=slave data. Write with bresp=2'b11 -> err=1.
- **Watchdog.** TIMEOUT_CYCLES=8, slave never asserts arready -> arvalid high for 8 cycles then low, resp_valid with err=1, rdata=0xFFFFFFFF. Next request accepted normally.
- **Reset mid-transfer.** Reset during WR_RESP -> next cycle all valids=0, cpu_req_ready=1, no resp_valid pulse. A following read completes correctly.
- **Back-to-back.** Request held valid continuously -> second accept occurs the cycle after resp_valid; no lost or duplicated transfers over 100 random reads and writes checked against a scoreboard.
